// File: rtl/ibex_fetch_realigner_if.sv
// Fetch-word input, branch redirect and instruction output of the IF-stage realigner.
// The slave modport is the realigner's view; the master modport is the surrounding IF stage.
interface ibex_fetch_realigner_if;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        fetch_err_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, fetch_err_i, branch_i, branch_addr_i, out_ready_i,
        output fetch_ready_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
    );

    modport master (
        output fetch_valid_i, fetch_rdata_i, fetch_err_i, branch_i, branch_addr_i, out_ready_i,
        input  fetch_ready_o, out_valid_o, out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o
    );
endinterface

// File: rtl/ibex_fetch_realigner.sv
// Realigns word-aligned fetch responses into RV32IC instructions at halfword granularity,
// tracking the PC and absorbing branch redirects to halfword-aligned targets.
module ibex_fetch_realigner #(
    parameter logic [31:0] BootAddr = 32'h0000_0080
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    ibex_fetch_realigner_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [15:0] r_hbuf;
    logic        r_hbuf_err;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [15:0] w_hbuf_next;
    logic        w_hbuf_err_next;

    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_accept;

    assign w_lo = bus.fetch_rdata_i[15:0];
    assign w_hi = bus.fetch_rdata_i[31:16];
    assign bus.out_addr_o = r_pc;
    // Handshake completes only when something is actually presented.
    assign w_accept = bus.out_valid_o & bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= EMPTY;
            r_pc       <= BootAddr;
            r_hbuf     <= 16'h0;
            r_hbuf_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_hbuf     <= w_hbuf_next;
            r_hbuf_err <= w_hbuf_err_next;
        end
    end

    always_comb begin
        bus.out_valid_o     = 1'b0;
        bus.fetch_ready_o   = 1'b0;
        bus.out_rdata_o     = 32'h0;
        bus.out_err_o       = 1'b0;
        bus.out_err_plus2_o = 1'b0;
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_hbuf_next         = r_hbuf;
        w_hbuf_err_next     = r_hbuf_err;

        if (!rst_ni) begin
            // Outputs stay quiet; the register block reloads everything.
        end else if (bus.branch_i) begin
            bus.fetch_ready_o = 1'b1;
            w_pc_next         = bus.branch_addr_i & 32'hFFFF_FFFE;
            w_state_next      = EMPTY;
            w_hbuf_err_next   = 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (bus.fetch_valid_i && !r_pc[1]) begin
                        bus.out_valid_o = 1'b1;
                        bus.out_err_o   = bus.fetch_err_i;
                        if (w_lo[1:0] == 2'b11) begin
                            bus.out_rdata_o   = bus.fetch_rdata_i;
                            bus.fetch_ready_o = bus.out_ready_i;
                            if (w_accept) w_pc_next = r_pc + 32'd4;
                        end else begin
                            bus.out_rdata_o   = {16'h0, w_lo};
                            bus.fetch_ready_o = bus.out_ready_i;
                            if (w_accept) begin
                                w_hbuf_next     = w_hi;
                                w_hbuf_err_next = bus.fetch_err_i;
                                w_pc_next       = r_pc + 32'd2;
                                w_state_next    = HALF;
                            end
                        end
                    end else if (bus.fetch_valid_i) begin
                        // Redirect landed on the upper halfword; the lower one is stale.
                        if (w_hi[1:0] != 2'b11 || bus.fetch_err_i) begin
                            bus.out_valid_o   = 1'b1;
                            bus.out_rdata_o   = {16'h0, w_hi};
                            bus.out_err_o     = bus.fetch_err_i;
                            bus.fetch_ready_o = bus.out_ready_i;
                            if (w_accept) w_pc_next = r_pc + 32'd2;
                        end else begin
                            bus.fetch_ready_o = 1'b1;
                            w_hbuf_next       = w_hi;
                            w_hbuf_err_next   = 1'b0;
                            w_state_next      = HALF;
                        end
                    end
                end
                HALF: begin
                    if (r_hbuf[1:0] != 2'b11 || r_hbuf_err) begin
                        bus.out_valid_o = 1'b1;
                        bus.out_rdata_o = {16'h0, r_hbuf};
                        bus.out_err_o   = r_hbuf_err;
                        if (w_accept) begin
                            w_pc_next    = r_pc + 32'd2;
                            w_state_next = EMPTY;
                        end
                    end else if (bus.fetch_valid_i) begin
                        bus.out_valid_o     = 1'b1;
                        bus.out_rdata_o     = {w_lo, r_hbuf};
                        bus.out_err_o       = bus.fetch_err_i;
                        bus.out_err_plus2_o = bus.fetch_err_i;
                        bus.fetch_ready_o   = bus.out_ready_i;
                        if (w_accept) begin
                            w_hbuf_next     = w_hi;
                            w_hbuf_err_next = bus.fetch_err_i;
                            w_pc_next       = r_pc + 32'd4;
                        end
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// Directed-vector bench for the fetch realigner: one task per scenario, inline checks.
module tb_ibex_fetch_realigner;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    ibex_fetch_realigner_if bus ();

    ibex_fetch_realigner #(.BootAddr(32'h0000_0080)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic e, input logic rdy);
        bus.fetch_valid_i = v;
        bus.fetch_rdata_i = w;
        bus.fetch_err_i   = e;
        bus.out_ready_i   = rdy;
        bus.branch_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(1'b1, 32'h0041_0113, 1'b0, 1'b1);
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0200;
        next_cycle();
        @(negedge clk_i);
        n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.fetch_ready_o); end
        n_checks++; if (bus.out_addr_o !== 32'h80) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000080", bus.out_addr_o); end
        next_cycle();
        rst_ni = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_addr_o !== 32'h80) begin n_fail++; $display("FAIL reset_branch_ignored got=%h exp=00000080", bus.out_addr_o); end
        n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got=%b exp=0", bus.out_valid_o); end
        $display("test_reset: pc=%h", bus.out_addr_o);
    endtask

    task automatic test_uncompressed();
        do_reset();
        drive(1'b1, 32'h0041_0113, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o, bus.out_err_o} !== 3'b110) begin n_fail++; $display("FAIL unc0_flags got=%b exp=110", {bus.out_valid_o, bus.fetch_ready_o, bus.out_err_o}); end
        n_checks++; if (bus.out_rdata_o !== 32'h0041_0113) begin n_fail++; $display("FAIL unc0_rdata got=%h exp=00410113", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h80) begin n_fail++; $display("FAIL unc0_addr got=%h exp=00000080", bus.out_addr_o); end
        next_cycle();
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_0013) begin n_fail++; $display("FAIL unc1_rdata got=%h exp=00000013", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h84) begin n_fail++; $display("FAIL unc1_addr got=%h exp=00000084", bus.out_addr_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL unc1_ready got=%b exp=1", bus.fetch_ready_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_addr_o !== 32'h88) begin n_fail++; $display("FAIL unc_end_addr got=%h exp=00000088", bus.out_addr_o); end
        $display("test_uncompressed: pc=%h", bus.out_addr_o);
    endtask

    task automatic test_compressed_pair();
        do_reset();
        drive(1'b1, 32'h4505_4501, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_4501) begin n_fail++; $display("FAIL cpair0_rdata got=%h exp=00004501", bus.out_rdata_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL cpair0_ready got=%b exp=1", bus.fetch_ready_o); end
        next_cycle();
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_4505) begin n_fail++; $display("FAIL cpair1_rdata got=%h exp=00004505", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h82) begin n_fail++; $display("FAIL cpair1_addr got=%h exp=00000082", bus.out_addr_o); end
        n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o} !== 2'b10) begin n_fail++; $display("FAIL cpair1_hs got=%b exp=10", {bus.out_valid_o, bus.fetch_ready_o}); end
        next_cycle();
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_0013) begin n_fail++; $display("FAIL cpair2_rdata got=%h exp=00000013", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h84) begin n_fail++; $display("FAIL cpair2_addr got=%h exp=00000084", bus.out_addr_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL cpair2_ready got=%b exp=1", bus.fetch_ready_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        $display("test_compressed_pair: done");
    endtask

    task automatic test_straddle();
        do_reset();
        drive(1'b1, 32'h0113_4501, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_4501) begin n_fail++; $display("FAIL strad0_rdata got=%h exp=00004501", bus.out_rdata_o); end
        next_cycle();
        drive(1'b1, 32'hBEEF_0041, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0041_0113) begin n_fail++; $display("FAIL strad1_rdata got=%h exp=00410113", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h82) begin n_fail++; $display("FAIL strad1_addr got=%h exp=00000082", bus.out_addr_o); end
        n_checks++; if ({bus.fetch_ready_o, bus.out_err_plus2_o} !== 2'b10) begin n_fail++; $display("FAIL strad1_flags got=%b exp=10", {bus.fetch_ready_o, bus.out_err_plus2_o}); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.out_addr_o} !== {1'b0, 32'h86}) begin n_fail++; $display("FAIL strad2_wait got=%b/%h exp=0/00000086", bus.out_valid_o, bus.out_addr_o); end
        next_cycle();
        drive(1'b1, 32'h0000_2083, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h2083_BEEF) begin n_fail++; $display("FAIL strad3_rdata got=%h exp=2083beef", bus.out_rdata_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        $display("test_straddle: done");
    endtask

    task automatic test_branch();
        do_reset();
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0103;
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o} !== 2'b01) begin n_fail++; $display("FAIL br0_hs got=%b exp=01", {bus.out_valid_o, bus.fetch_ready_o}); end
        next_cycle();
        drive(1'b1, 32'h4501_1234, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0000_4501) begin n_fail++; $display("FAIL br1_rdata got=%h exp=00004501", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h102) begin n_fail++; $display("FAIL br1_addr got=%h exp=00000102", bus.out_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.out_addr_o} !== {1'b0, 32'h104}) begin n_fail++; $display("FAIL br2_after got=%b/%h exp=0/00000104", bus.out_valid_o, bus.out_addr_o); end
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0102;
        next_cycle();
        drive(1'b1, 32'h0013_1234, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o} !== 2'b01) begin n_fail++; $display("FAIL br3_absorb got=%b exp=01", {bus.out_valid_o, bus.fetch_ready_o}); end
        next_cycle();
        drive(1'b1, 32'h5555_0041, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_rdata_o !== 32'h0041_0013) begin n_fail++; $display("FAIL br4_rdata got=%h exp=00410013", bus.out_rdata_o); end
        n_checks++; if (bus.out_addr_o !== 32'h102) begin n_fail++; $display("FAIL br4_addr got=%h exp=00000102", bus.out_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        $display("test_branch: done");
    endtask

    task automatic test_err_straddle();
        do_reset();
        drive(1'b1, 32'h0113_4501, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 32'h0000_0041, 1'b1, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_err_o, bus.out_err_plus2_o} !== 2'b11) begin n_fail++; $display("FAIL errs0_flags got=%b exp=11", {bus.out_err_o, bus.out_err_plus2_o}); end
        n_checks++; if (bus.out_addr_o !== 32'h82) begin n_fail++; $display("FAIL errs0_addr got=%h exp=00000082", bus.out_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o, bus.fetch_ready_o} !== 4'b1100) begin n_fail++; $display("FAIL errs1_hbuf got=%b exp=1100", {bus.out_valid_o, bus.out_err_o, bus.out_err_plus2_o, bus.fetch_ready_o}); end
        n_checks++; if (bus.out_addr_o !== 32'h86) begin n_fail++; $display("FAIL errs1_addr got=%h exp=00000086", bus.out_addr_o); end
        next_cycle();
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.out_addr_o} !== {1'b0, 32'h88}) begin n_fail++; $display("FAIL errs2_after got=%b/%h exp=0/00000088", bus.out_valid_o, bus.out_addr_o); end
        $display("test_err_straddle: done");
    endtask

    task automatic test_stall_then_branch();
        do_reset();
        drive(1'b1, 32'h0113_4501, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 32'h0000_0041, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o} !== 2'b10) begin n_fail++; $display("FAIL stall%0d_hs got=%b exp=10", i, {bus.out_valid_o, bus.fetch_ready_o}); end
            n_checks++; if ({bus.out_rdata_o, bus.out_addr_o} !== {32'h0041_0113, 32'h82}) begin n_fail++; $display("FAIL stall%0d_data got=%h@%h exp=00410113@00000082", i, bus.out_rdata_o, bus.out_addr_o); end
            next_cycle();
        end
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0200;
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.fetch_ready_o} !== 2'b01) begin n_fail++; $display("FAIL stallbr_hs got=%b exp=01", {bus.out_valid_o, bus.fetch_ready_o}); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_valid_o, bus.out_addr_o} !== {1'b0, 32'h200}) begin n_fail++; $display("FAIL stallbr_stale got=%b/%h exp=0/00000200", bus.out_valid_o, bus.out_addr_o); end
        next_cycle();
        drive(1'b1, 32'h0000_4501, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_rdata_o, bus.out_addr_o} !== {32'h0000_4501, 32'h200}) begin n_fail++; $display("FAIL stallbr_new got=%h@%h exp=00004501@00000200", bus.out_rdata_o, bus.out_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        $display("test_stall_then_branch: done");
    endtask

    task automatic test_pc_wrap();
        do_reset();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'hFFFF_FFFE;
        next_cycle();
        drive(1'b1, 32'h4501_0000, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if ({bus.out_rdata_o, bus.out_addr_o} !== {32'h0000_4501, 32'hFFFF_FFFE}) begin n_fail++; $display("FAIL wrap0 got=%h@%h exp=00004501@fffffffe", bus.out_rdata_o, bus.out_addr_o); end
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (bus.out_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap1_addr got=%h exp=00000000", bus.out_addr_o); end
        $display("test_pc_wrap: pc=%h", bus.out_addr_o);
    endtask

    initial begin
        rst_ni            = 1'b0;
        bus.branch_addr_i = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        test_reset();
        test_uncompressed();
        test_compressed_pair();
        test_straddle();
        test_branch();
        test_err_straddle();
        test_stall_then_branch();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_fetch_realigner.md
Name: ibex_fetch_realigner

Overview:
- Sits directly upstream of the compressed instruction decoder in the IF stage.
- Consumes word-aligned 32-bit fetch responses from the prefetch buffer. Extracts RV32IC instructions at halfword granularity, including 32-bit instructions that straddle two fetch words.
- Presents one instruction per handshake with its PC and error flags.
- Tracks the current PC and handles branch redirects to halfword-aligned targets.

Parameters:
- BootAddr, 32'h0000_0080, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word consumed this cycle
- fetch_rdata_i  in  32  fetch word, little-endian halfwords
- fetch_err_i  in  1  bus error on this word
- branch_i  in  1  redirect request
- branch_addr_i  in  32  redirect target; bit0 ignored (treated as 0)
- out_valid_o  out  1  instruction valid
- out_ready_i  in  1  downstream accepts
- out_rdata_o  out  32  instruction; compressed ones zero-extended, i.e. {16'h0, hw}
- out_addr_o  out  32  PC of presented instruction
- out_err_o  out  1  fetch error associated with instruction
- out_err_plus2_o  out  1  error came from the second word of a straddling instruction

Behaviour:
- Reset (rst_ni=0 at clock edge):
  - state=EMPTY, pc=BootAddr, hbuf=0, hbuf_err=0.
  - out_valid_o=0, fetch_ready_o=0 while in reset.
- State: 2-state FSM EMPTY / HALF.
  - HALF holds one upper halfword hbuf (+hbuf_err) taken from a previously consumed word.
- Outputs are combinational from state and inputs: zero-latency pass-through.
  - fetch_ready_o may depend on out_ready_i.
  - out_valid_o must not depend on out_ready_i.
- Compressed test: hw[1:0]!=2'b11.
- EMPTY, pc[1]=0, fetch_valid_i=1:
  - word[1:0]==11: out_rdata_o=word, err=fetch_err_i. On accept: consume word, pc+=4, stay EMPTY.
  - Otherwise: out_rdata_o={16'h0,word[15:0]}. On accept: consume word, hbuf=word[31:16], hbuf_err=fetch_err_i, pc+=2, go HALF.
- EMPTY, pc[1]=1 (only after a redirect), fetch_valid_i=1:
  - word[15:0] is discarded.
  - Upper halfword compressed, or fetch_err_i=1: out_rdata_o={16'h0,word[31:16]}, err=fetch_err_i. On accept: consume, pc+=2, stay EMPTY.
  - Otherwise: fetch_ready_o=1 with out_valid_o=0; store hbuf=word[31:16], go HALF, pc unchanged.
- HALF, hbuf compressed or hbuf_err=1:
  - out_valid_o=1 regardless of fetch_valid_i; out_rdata_o={16'h0,hbuf}; out_err_o=hbuf_err; fetch_ready_o=0.
  - On accept: pc+=2 (hbuf_err: pc+=2 as well), go EMPTY.
- HALF, hbuf uncompressed: requires fetch_valid_i.
  - out_rdata_o={word[15:0],hbuf}; out_err_o=fetch_err_i; out_err_plus2_o=fetch_err_i.
  - On accept: consume, hbuf=word[31:16], hbuf_err=fetch_err_i, pc+=4, stay HALF.
- No valid input where one is needed: out_valid_o=0, fetch_ready_o=0.
- out_err_plus2_o=0 in every case except HALF/straddle.
- Redirect: branch_i=1 has priority over all other events.
  - That cycle: out_valid_o=0; fetch_ready_o=1 (any presented word is dropped).
  - Next cycle: pc={branch_addr_i[31:1],1'b0}, state=EMPTY, hbuf_err=0.
  - branch_i during reset: reset wins.
- Stall: out_valid_o=1 and out_ready_i=0 → all state held; outputs stable while inputs stable.
- pc wraps modulo 2^32 (32'hFFFF_FFFE+2 = 0); no flag raised.
- The block never inspects bits beyond the compressed test; legality checks are the downstream decoder's job.

Test Plan:
- Reset, then words 32'h0041_0113, 32'h0000_0013 with out_ready_i=1 → two outputs at addr 0x80, 0x84, both non-compressed, err=0.
- Word 32'h4505_4501 (two c.li) → out {16'h0,4501}@0x80, then {16'h0,4505}@0x82 with fetch_ready_o=0 on the second; next word consumed at 0x84.
- Word 32'h0113_4501, then 32'hxxxx_0041 → {16'h0,4501}@0x80, then straddled 32'h0041_0113@0x82, pc→0x86, state HALF.
- branch_i with branch_addr_i=0x102, word 32'h4501_1234 → low half dropped, {16'h0,4501}@0x102; repeat with uncompressed upper half → no output, HALF, next word completes instruction @0x102.
- Straddle where the second word has fetch_err_i=1 → out_err_o=1, out_err_plus2_o=1, addr=start halfword.
- out_ready_i=0 for 3 cycles mid-HALF, then branch_i → outputs stable while stalled; after branch, no stale hbuf output and out_addr_o equals the new target.
